// File: rtl/dpot_pkg.sv
// Constants shared between the dpot SPI master and the dpot_responder model.
package dpot_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam int         DPOT_FRAME_BITS  = 8;
  localparam logic [7:0] DPOT_RESET_WIPER = 8'h80;

  // Bit counter increment that sticks at all-ones so oversized frames never wrap back to a valid count.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync2ff.sv
// Single-bit two-stage synchroniser with a configurable reset value.
module sync2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/dpot_responder.sv
// Receive side of the Pmod DPOT: oversamples nCS/SCLK/MOSI, collects 8-bit MSB-first
// frames and reports the accepted wiper value with new_val / frame_err pulses.
module dpot_responder
  import dpot_pkg::*;
#(
  parameter logic [7:0] RESET_WIPER = DPOT_RESET_WIPER,
  parameter int         FRAME_BITS  = DPOT_FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nCS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic [7:0] wiper,
  output logic       new_val,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] FRAME_CNT = 4'(FRAME_BITS);

  logic       ncs_s, sclk_s, mosi_s;
  logic       ncs_rise_s, ncs_fall_s, sclk_rise_s;
  logic       ncs_prev_q, sclk_prev_q;
  logic [1:0] flush_q, flush_d;
  logic       armed_q, armed_d;
  logic [0:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] wiper_q, wiper_d;
  logic       new_val_q, new_val_d;
  logic       frame_err_q, frame_err_d;

  sync2ff #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst_n(rst), .d_i(nCS),  .q_o(ncs_s));
  sync2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst), .d_i(SCLK), .q_o(sclk_s));
  sync2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst), .d_i(MOSI), .q_o(mosi_s));

  assign ncs_rise_s  = ncs_s & ~ncs_prev_q;
  assign ncs_fall_s  = ~ncs_s & ncs_prev_q;
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;

  // A frame may only start once nCS has been seen high after the reset value left the
  // synchroniser, so a chip select still low at reset release is not taken as a fall.
  always_comb begin
    flush_d     = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
    armed_d     = armed_q | ((flush_q == 2'd3) & ncs_s);
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    wiper_d     = wiper_q;
    new_val_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall_s && armed_q) begin
          state_d = ST_RECV;
          shift_d = 8'h00;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (ncs_rise_s) begin
          state_d = ST_IDLE;
          if (cnt_q == FRAME_CNT) begin
            wiper_d   = shift_q;
            new_val_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise_s) begin
          shift_d = {shift_q[6:0], mosi_s};
          cnt_d   = sat_inc4(cnt_q);
        end else begin
          state_d = ST_RECV;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ncs_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
      flush_q     <= 2'd0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      cnt_q       <= 4'd0;
      wiper_q     <= RESET_WIPER;
      new_val_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ncs_prev_q  <= ncs_s;
      sclk_prev_q <= sclk_s;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wiper_q     <= wiper_d;
      new_val_q   <= new_val_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wiper     = wiper_q;
  assign new_val   = new_val_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ST_RECV);

endmodule

// File: tb/tb_dpot_responder.sv
// Self-checking bench for dpot_responder: directed frame table, corner sequences and random frames.
module tb_dpot_responder;

  logic       clk = 1'b0;
  logic       rst, nCS, SCLK, MOSI;
  logic [7:0] wiper;
  logic       new_val, frame_err, busy;

  int errors = 0;
  int checks = 0;
  int nv_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] model_wiper;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic        exp_ok;
    logic [7:0]  exp_wiper;
  } vec_t;

  vec_t vecs[7];

  dpot_responder dut (
    .clk(clk), .rst(rst), .nCS(nCS), .SCLK(SCLK), .MOSI(MOSI),
    .wiper(wiper), .new_val(new_val), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_val)   nv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] data, input int n, input int hl);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = data[i];
      wait_clk(hl);
      SCLK = 1'b1;
      wait_clk(hl);
      SCLK = 1'b0;
    end
  endtask

  // One full frame, then check the pulse lands exactly three samples after nCS rises.
  task automatic do_frame(input string name, input logic [31:0] data, input int n, input int hl,
                          input logic exp_ok, input logic [7:0] exp_wiper);
    logic [4:0] nvp, fep;
    nCS = 1'b0;
    wait_clk(4);
    check({name, "_busy"}, 32'(busy), 32'd1);
    send_bits(data, n, hl);
    wait_clk(hl);
    nCS = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nvp[i] = new_val;
      fep[i] = frame_err;
    end
    check({name, "_new_val"}, 32'(nvp), exp_ok ? 32'd4 : 32'd0);
    check({name, "_frame_err"}, 32'(fep), exp_ok ? 32'd0 : 32'd4);
    check({name, "_wiper"}, 32'(wiper), 32'(exp_wiper));
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int nv0, fe0, n, hl;
    logic [31:0] d;
    logic ok;

    vecs[0] = '{32'h0000_00A5,  8, 1'b1, 8'hA5};
    vecs[1] = '{32'h0000_0055,  7, 1'b0, 8'hA5};
    vecs[2] = '{32'h0000_01FF,  9, 1'b0, 8'hA5};
    vecs[3] = '{32'h0000_0000,  0, 1'b0, 8'hA5};
    vecs[4] = '{32'h00FF_FFFF, 24, 1'b0, 8'hA5};
    vecs[5] = '{32'h0000_A5A5, 16, 1'b0, 8'hA5};
    vecs[6] = '{32'h0000_005A,  8, 1'b1, 8'h5A};

    rst = 1'b0; nCS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wait_clk(3);
    check("rst_wiper", 32'(wiper), 32'h80);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({new_val, frame_err}), 32'd0);
    rst = 1'b1;
    wait_clk(6);
    check("post_rst_wiper", 32'(wiper), 32'h80);
    check("post_rst_pulse_cnt", 32'(nv_cnt + fe_cnt), 32'd0);
    model_wiper = 8'h80;

    for (int v = 0; v < 7; v++) begin
      do_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].nbits, 4, vecs[v].exp_ok, vecs[v].exp_wiper);
      wait_clk(3);
    end
    model_wiper = 8'h5A;

    // SCLK activity with nCS high must be ignored.
    nv0 = nv_cnt; fe0 = fe_cnt;
    MOSI = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_clk(4); SCLK = 1'b1; wait_clk(4); SCLK = 1'b0;
    end
    wait_clk(5);
    check("ncs_high_nv", 32'(nv_cnt - nv0), 32'd0);
    check("ncs_high_fe", 32'(fe_cnt - fe0), 32'd0);
    check("ncs_high_busy", 32'(busy), 32'd0);
    check("ncs_high_wiper", 32'(wiper), 32'(model_wiper));

    // Reset in the middle of a frame, released while nCS is still low.
    nCS = 1'b0;
    wait_clk(4);
    send_bits(32'hF, 4, 4);
    rst = 1'b0;
    wait_clk(2);
    check("midrst_wiper", 32'(wiper), 32'h80);
    check("midrst_busy", 32'(busy), 32'd0);
    model_wiper = 8'h80;
    rst = 1'b1;
    wait_clk(6);
    check("rst_ncs_low_busy", 32'(busy), 32'd0);
    fe0 = fe_cnt; nv0 = nv_cnt;
    nCS = 1'b1;
    wait_clk(6);
    check("rst_ncs_rise_fe", 32'(fe_cnt - fe0), 32'd0);
    check("rst_ncs_rise_nv", 32'(nv_cnt - nv0), 32'd0);
    do_frame("after_rst", 32'h3C, 8, 4, 1'b1, 8'h3C);
    model_wiper = 8'h3C;
    wait_clk(3);

    // Back-to-back frames with a minimum 3-clock nCS gap.
    nv0 = nv_cnt; fe0 = fe_cnt;
    nCS = 1'b0; wait_clk(4); send_bits(32'h01, 8, 4); wait_clk(4); nCS = 1'b1;
    wait_clk(3);
    nCS = 1'b0; wait_clk(4); send_bits(32'hFE, 8, 4); wait_clk(4); nCS = 1'b1;
    wait_clk(6);
    check("b2b_nv", 32'(nv_cnt - nv0), 32'd2);
    check("b2b_fe", 32'(fe_cnt - fe0), 32'd0);
    check("b2b_wiper", 32'(wiper), 32'hFE);
    model_wiper = 8'hFE;
    wait_clk(3);

    // Random frames against the reference: only exactly eight bits update the wiper.
    for (int r = 0; r < 24; r++) begin
      n  = ($urandom_range(0, 1) == 0) ? 8 : int'($urandom_range(0, 12));
      d  = $urandom;
      hl = int'($urandom_range(3, 5));
      ok = (n == 8);
      if (ok) model_wiper = d[7:0];
      do_frame($sformatf("rnd%0d", r), d, n, hl, ok, model_wiper);
      wait_clk(int'($urandom_range(3, 6)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
